// File: rtl/serial_subtract_seq.sv
// Bit-serial unsigned subtractor: one subtract cell plus a borrow flop processes
// A - B LSB-first over WIDTH cycles, sequenced by a start/busy/done handshake.
module serial_subtract_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_r_sr;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;

  logic             w_d;
  logic             w_br_nxt;
  logic             w_last;

  assign w_d      = r_a_sr[0] ^ r_b_sr[0] ^ r_borrow;
  assign w_br_nxt = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_borrow);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr       <= '0;
      r_b_sr       <= '0;
      r_r_sr       <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_r_sr   <= {w_d, r_r_sr[WIDTH-1:1]};
          r_borrow <= w_br_nxt;
          // Final bit: publish the fully shifted result on the same edge that enters DONE.
          if (w_last) begin
            r_diff       <= {w_d, r_r_sr[WIDTH-1:1]};
            r_borrow_out <= w_br_nxt;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtract_seq.sv
// Scoreboard bench for serial_subtract_seq: stimulus pushes expected A-B results,
// a monitor pops and compares on every done pulse.
module tb_serial_subtract_seq;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         br;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  exp_t q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  int   last_done  = -1;
  bit   period_chk = 1'b0;
  int   done_cnt   = 0;

  serial_subtract_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   dv;
    dv   = int'(av) - int'(bv);
    e.br = (dv < 0);
    e.d  = W'((dv + (1 << W)) % (1 << W));
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("diff", 64'(diff), 64'(e.d));
        check("borrow_out", 64'(borrow_out), 64'(e.br));
      end
      if (period_chk && last_done >= 0)
        check("done_period", 64'(cyc - last_done), 64'(W + 2));
      last_done = cyc;
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    wait_idle();
    a     = av;
    b     = bv;
    start = 1'b1;
    q.push_back(model(av, bv));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  task automatic drain();
    wait_idle();
    check("scoreboard_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    int dc;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #2;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_diff", 64'(diff), 64'(0));
    check("rst_borrow", 64'(borrow_out), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 200 - 55 with busy-length measurement
    wait_idle();
    a     = 8'd200;
    b     = 8'd55;
    start = 1'b1;
    q.push_back(model(8'd200, 8'd55));
    @(posedge clk);
    #1;
    start = 1'b0;
    nb = 0;
    @(negedge clk);
    while (busy && nb < 50) begin
      nb++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(nb), 64'(W + 1));
    check("hold_diff_145", 64'(diff), 64'(145));

    issue(8'd5, 8'd9);
    issue(8'hA5, 8'hA5);
    issue(8'd0, 8'd255);
    issue(8'd255, 8'd0);
    issue(8'd0, 8'd0);
    drain();

    // start during RUN must be ignored
    dc = done_cnt;
    issue(8'd9, 8'd2);
    repeat (3) @(negedge clk);
    a     = 8'd7;
    b     = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    check("ignored_start_done_count", 64'(done_cnt - dc), 64'(1));
    check("ignored_start_diff", 64'(diff), 64'(7));
    repeat (5) @(negedge clk);
    check("hold_diff_7", 64'(diff), 64'(7));
    check("hold_busy", 64'(busy), 64'(0));

    // start held high: back-to-back operations
    dc         = done_cnt;
    period_chk = 1'b1;
    last_done  = -1;
    a          = 8'd77;
    b          = 8'd90;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 1'b1;
      if (!busy) q.push_back(model(a, b));
    end
    @(negedge clk);
    start = 1'b0;
    drain();
    period_chk = 1'b0;
    check("held_ops", 64'(done_cnt - dc), 64'(3));

    // reset in the middle of RUN
    issue(8'd200, 8'd100);
    dc = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(q.pop_back());
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_diff", 64'(diff), 64'(0));
    check("abort_borrow", 64'(borrow_out), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("abort_no_done", 64'(done_cnt - dc), 64'(0));
    issue(8'd100, 8'd1);
    drain();
    check("post_reset_diff", 64'(diff), 64'(99));

    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom), W'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
